sysarr_os_engine: RTL
=====================

Name: sysarr_os_engine

Overview:
Parametrised N x N output-stationary systolic matrix-multiply engine that computes C = A x B on signed two's-complement integers. It buffers both operand matrices from a valid/ready stream, then generates the diagonal input skew internally and runs the grid of multiply-accumulate cells. When the grid finishes, it streams out C one row per beat. It generalises the fixed 3x3 array to arbitrary N, data width and accumulator width, and adds load/compute/drain sequencing with flow control.

Parameters:
N, 4, array dimension; matrices are N x N; N >= 2.
DW, 16, operand width, signed.
AW, 2*DW+$clog2(N), accumulator and result width, signed; AW >= 2*DW.

Ports:
clock  input  1  single clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  engine accepts a beat.
in_a  input  N*DW  column k of A; lane i (bits i*DW +: DW) = A[i][k].
in_b  input  N*DW  row k of B; lane j = B[k][j].
out_valid  output  1  result row valid.
out_ready  input  1  downstream accepts the row.
out_row  output  N*AW  row r of C; lane j = C[r][j].
out_idx  output  $clog2(N)  row index r.
out_last  output  1  high with out_idx == N-1.
out_sat  output  1  a lane of the current row saturated (macro only; else 0).
busy  output  1  high in COMPUTE or DRAIN.

Behaviour:
- Reset, asserted at any time including mid-operation: state = LOAD, beat and row counters = 0, all accumulators and pipeline registers = 0, in_ready = 1, out_valid = 0, out_row = 0, out_idx = 0, out_last = 0, out_sat = 0, busy = 0. Buffered data is discarded.
- FSM LOAD -> COMPUTE -> DRAIN -> LOAD.
- LOAD: in_ready = 1. Each in_valid & in_ready edge stores the beat at index k = beat counter and increments the counter. The counter counts only accepted beats, so bubbles are allowed. On the beat with k = N-1: clear all accumulators, counter -> 0, next state COMPUTE.
- COMPUTE: in_ready = 0, busy = 1. Lasts exactly 3N-1 cycles, counted by cycle counter t = 0..3N-2.
  - Row-edge feed for row i at cycle t: A[i][t-i] when 0 <= t-i < N, else 0.
  - Column-edge feed for column j: B[t-j][j] when 0 <= t-j < N, else 0.
  - Cell (i,j) registers its a operand to cell (i,j+1) and its b operand to cell (i+1,j), each with one cycle of latency.
  - Each cycle, cell (i,j) does acc += sext(a*b) on the full 2*DW product, wrapping mod 2^AW.
  - Zero padding guarantees no spurious products.
- DRAIN: out_valid = 1, out_row = accumulators of row r, out_idx = r, out_last = (r == N-1). busy = 1.
  - r advances only on out_valid & out_ready. out_row, out_idx and out_last hold stable while out_ready = 0.
  - After the accept at r = N-1, the next state is LOAD with out_valid = 0 and in_ready = 1 on the following cycle.
- No overlap: the next matrix cannot load until the drain completes.
- Minimum latency, last load beat to first out_valid: 3N cycles (N=4: 12).
- in_valid outside LOAD is ignored, and in_a/in_b are not sampled.

Optional Feature:
SYSARR_SATURATE_EN
- Defined: each accumulate saturates to [-2^(AW-1), 2^(AW-1)-1] instead of wrapping.
  - A per-cell sticky flag sets on any clamp. The flag clears with the accumulators.
  - out_sat = OR of row r's flags during DRAIN.
- Undefined: accumulation wraps, and out_sat is constant 0.

Test Plan:
1. N=4, A = identity, B[k][j] = 4k+j+1 -> four beats out_idx 0..3 with rows {1,2,3,4}..{13,14,15,16}; out_last only on beat 3; first out_valid 12 cycles after the last load beat.
2. N=4, A all -1, B all 2 -> every lane of every row = -8 (sign-extended to AW); out_sat = 0.
3. Hold out_ready = 0 for 5 cycles at r = 1 -> out_row/out_idx stable, no row lost or duplicated, in_ready = 0 throughout, busy = 1.
4. Insert 3-cycle in_valid gaps between load beats -> results identical to contiguous loading; COMPUTE entered the cycle after the 4th accepted beat.
5. Pulse reset_n low at COMPUTE t = 5 -> all outputs reset immediately, in_ready = 1 after release; a following identity x B run returns B exactly, with no stale accumulation.
6. DW=8, AW=16, N=4, A and B all 127 -> with SYSARR_SATURATE_EN, every lane = 32767 and out_sat = 1; without it, every lane = -1020 (64516 mod 2^16) and out_sat = 0.

Source files
------------

// File: rtl/sysarr_os_engine.sv
// sysarr_os_engine: N x N output-stationary systolic matrix multiply (C = A x B, signed).
// Operands stream in one column of A / row of B per beat. The engine skews them into the
// MAC grid, then drains C one row per beat.
// Optional macro SYSARR_SATURATE_EN: saturating accumulation with sticky per-cell clamp flags.
module sysarr_os_engine #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 2 * DW + $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_a,
    input  logic [N*DW-1:0]      in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*AW-1:0]      out_row,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 out_sat,
    output logic                 busy
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned TW = $clog2(3 * N);
    localparam int unsigned PW = 2 * DW;

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]      r_state, w_state_nxt;
    logic [IW-1:0]   r_beat, w_beat_nxt;
    logic [IW-1:0]   r_row, w_row_nxt;
    logic [TW-1:0]   r_t, w_t_nxt;
    logic            w_load, w_start;

    logic            r_in_ready, r_out_valid, r_out_last, r_out_sat, r_busy;
    logic [N*AW-1:0] r_out_row;
    logic [IW-1:0]   r_out_idx;
    logic            w_in_ready_nxt, w_out_valid_nxt, w_out_last_nxt, w_out_sat_nxt, w_busy_nxt;
    logic [N*AW-1:0] w_out_row_nxt;
    logic [IW-1:0]   w_out_idx_nxt;

    logic signed [DW-1:0] r_abuf [N][N];   // [k][i] = A[i][k]
    logic signed [DW-1:0] r_bbuf [N][N];   // [k][j] = B[k][j]
    logic signed [DW-1:0] w_feed_a [N];
    logic signed [DW-1:0] w_feed_b [N];
    logic signed [DW-1:0] w_pa [N][N];
    logic signed [DW-1:0] w_pb [N][N];
    logic signed [AW-1:0] w_acc [N][N];
    logic                 w_flag [N][N];
    logic [N*AW-1:0]      w_row_data;
    logic                 w_row_sat;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;
    assign busy      = r_busy;

    // Next-state, counters and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_row_nxt   = r_row;
        w_t_nxt     = r_t;
        w_load      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_load = 1'b1;
                    if (r_beat == IW'(N - 1)) begin
                        w_beat_nxt  = '0;
                        w_t_nxt     = '0;
                        w_start     = 1'b1;
                        w_state_nxt = S_COMPUTE;
                    end else begin
                        w_beat_nxt = r_beat + IW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (r_t == TW'(3 * N - 2)) begin
                    w_row_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            S_DRAIN: begin
                if (r_out_valid && out_ready) begin
                    if (r_row == IW'(N - 1)) begin
                        w_row_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_row_nxt = r_row + IW'(1);
                    end
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
        w_in_ready_nxt  = (w_state_nxt == S_LOAD);
        w_busy_nxt      = (w_state_nxt != S_LOAD);
        w_out_valid_nxt = (w_state_nxt == S_DRAIN);
        w_out_row_nxt   = w_out_valid_nxt ? w_row_data : '0;
        w_out_idx_nxt   = w_out_valid_nxt ? w_row_nxt : '0;
        w_out_last_nxt  = w_out_valid_nxt && (w_row_nxt == IW'(N - 1));
        w_out_sat_nxt   = w_out_valid_nxt && w_row_sat;
    end

    // State, counters and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_LOAD;
            r_beat      <= '0;
            r_row       <= '0;
            r_t         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_row       <= w_row_nxt;
            r_t         <= w_t_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_row   <= w_out_row_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_sat   <= w_out_sat_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Operand buffers: one A column and one B row per accepted beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    r_abuf[k][i] <= '0;
                    r_bbuf[k][i] <= '0;
                end
            end
        end else if (w_load) begin
            for (int i = 0; i < N; i++) begin
                r_abuf[r_beat][i] <= in_a[i*DW +: DW];
                r_bbuf[r_beat][i] <= in_b[i*DW +: DW];
            end
        end
    end

    // Diagonal skew: edge lane i carries operand k at cycle t = i + k, zero otherwise.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_feed_a[i] = '0;
            w_feed_b[i] = '0;
            for (int k = 0; k < N; k++) begin
                if ((r_state == S_COMPUTE) && (32'(r_t) == 32'(i + k))) begin
                    w_feed_a[i] = r_abuf[k][i];
                    w_feed_b[i] = r_bbuf[k][i];
                end
            end
        end
    end

    // Drain row select; the grid only adds zeros on the last compute cycle, so accumulators are final.
    always_comb begin
        w_row_data = '0;
        w_row_sat  = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_row_data[j*AW +: AW] = w_acc[w_row_nxt][j];
            w_row_sat              = w_row_sat | w_flag[w_row_nxt][j];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DW-1:0] w_a, w_b;
            logic signed [PW-1:0] w_ax, w_bx, w_prod;
            logic signed [AW-1:0] w_acc_nxt;
            logic signed [DW-1:0] r_pa, r_pb;
            logic signed [AW-1:0] r_acc;

            if (gj == 0) begin : g_a_edge
                assign w_a = w_feed_a[gi];
            end else begin : g_a_int
                assign w_a = w_pa[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b = w_feed_b[gj];
            end else begin : g_b_int
                assign w_b = w_pb[gi-1][gj];
            end

            assign w_ax   = PW'(w_a);
            assign w_bx   = PW'(w_b);
            assign w_prod = w_ax * w_bx;

`ifdef SYSARR_SATURATE_EN
            logic signed [AW:0] w_sum;
            logic               w_ovf;
            logic               r_flag;
            assign w_sum     = (AW+1)'(r_acc) + (AW+1)'(w_prod);
            assign w_ovf     = w_sum[AW] ^ w_sum[AW-1];
            assign w_acc_nxt = !w_ovf ? w_sum[AW-1:0]
                             : (w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});

            // Sticky clamp flag, cleared together with the accumulator.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_flag <= 1'b0;
                end else if (w_start) begin
                    r_flag <= 1'b0;
                end else if (r_state == S_COMPUTE) begin
                    r_flag <= r_flag | w_ovf;
                end
            end
            assign w_flag[gi][gj] = r_flag;
`else
            assign w_acc_nxt      = r_acc + AW'(w_prod);
            assign w_flag[gi][gj] = 1'b0;
`endif

            // MAC cell: pass a right, b down, accumulate the product.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_pa  <= '0;
                    r_pb  <= '0;
                    r_acc <= '0;
                end else if (w_start) begin
                    r_pa  <= '0;
                    r_pb  <= '0;
                    r_acc <= '0;
                end else if (r_state == S_COMPUTE) begin
                    r_pa  <= w_a;
                    r_pb  <= w_b;
                    r_acc <= w_acc_nxt;
                end
            end

            assign w_pa[gi][gj]  = r_pa;
            assign w_pb[gi][gj]  = r_pb;
            assign w_acc[gi][gj] = r_acc;
        end
    end
endmodule
